freq_gate_ctrl: RTL and testbench

- Measurement sequencer for the frequency meter. It opens a fixed gate window and counts synchronised rising edges of sig during that window.
- After the gate closes, it converts the count to 4-digit packed BCD with a sequential double-dabble, one bit per cycle.
- The finished result is handed to the 7-segment display multiplexer over a valid/ready handshake.
- Supports single-shot and continuous measurement with a programmable hold-off between gates.

---
 rtl/freq_gate_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
`timescale 1ns/1ps
// Frequency-meter sequencer: counts synchronised rising edges of sig in a fixed
// gate window, converts the count to packed BCD and offers it over valid/ready.
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES    = 125000000,
  parameter int unsigned HOLDOFF_CYCLES = 12500000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        zybo_clk,
  input  logic        rst,
  input  logic        sig,
  input  logic        start,
  input  logic        mode_cont,
  input  logic        result_ready,
  output logic        gate,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  localparam int unsigned TMR_MAX = (GATE_CYCLES > HOLDOFF_CYCLES) ? GATE_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IT_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [IT_W-1:0]  CONV_LAST = IT_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATE    = 3'd1,
    S_CONVERT = 3'd2,
    S_PRESENT = 3'd3,
    S_HOLDOFF = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              sig_s1_q, sig_s2_q, sig_s3_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_now;
  logic              sat_q, sat_d, sat_now;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic [CNT_W-1:0]  bin_q, bin_d;
  logic [19:0]       dd_q, dd_d, dd_adj;
  logic [20:0]       dd_shift;
  logic [15:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              edge_det, gate_last, conv_last, hold_last;

  assign edge_det  = sig_s2_q & ~sig_s3_q;
  assign gate_last = (state_q == S_GATE) && (tmr_q == GATE_LAST);
  assign conv_last = (state_q == S_CONVERT) && (iter_q == CONV_LAST);
  assign hold_last = (tmr_q == HOLD_LAST);

  // State register
  always_ff @(posedge zybo_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Result port: result_valid is high for the whole PRESENT state; the transfer
  // happens on the rising clock edge where result_valid & result_ready, and
  // bcd_out/overflow never change while result_valid is high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start || mode_cont) state_d = S_GATE;
      S_GATE:    if (gate_last) state_d = S_CONVERT;
      S_CONVERT: if (conv_last) state_d = S_PRESENT;
      S_PRESENT: if (result_ready) state_d = mode_cont ? S_HOLDOFF : S_IDLE;
      S_HOLDOFF: begin
        if (!mode_cont)     state_d = S_IDLE;
        else if (hold_last) state_d = S_GATE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate         = (state_q == S_GATE);
    busy         = (state_q != S_IDLE);
    result_valid = (state_q == S_PRESENT);
    dbg_state    = state_q;
  end

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    dd_adj = dd_q;
    for (int k = 0; k < 5; k++) begin
      if (dd_q[4*k +: 4] >= 4'd5) dd_adj[4*k +: 4] = dd_q[4*k +: 4] + 4'd3;
    end
    dd_shift = {dd_adj, bin_q[CNT_W-1]};
  end

  always_comb begin
    cnt_now = cnt_q;
    sat_now = sat_q;
    if (state_q == S_GATE && edge_det && cnt_q != CNT_MAX) begin
      cnt_now = cnt_q + CNT_W'(1);
      sat_now = sat_q | (cnt_now == CNT_MAX);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    tmr_d  = tmr_q;
    iter_d = iter_q;
    bin_d  = bin_q;
    dd_d   = dd_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (state_d == S_GATE) begin
          cnt_d = '0;
          sat_d = 1'b0;
          tmr_d = '0;
        end
      end
      S_GATE: begin
        cnt_d = cnt_now;
        sat_d = sat_now;
        tmr_d = tmr_q + TMR_W'(1);
        if (gate_last) begin
          bin_d  = cnt_now;
          dd_d   = '0;
          iter_d = '0;
        end
      end
      S_CONVERT: begin
        bin_d  = bin_q << 1;
        dd_d   = dd_shift[19:0];
        iter_d = iter_q + IT_W'(1);
        if (conv_last) begin
          ovf_d = sat_q | (dd_shift[20:16] != 5'd0);
          bcd_d = ovf_d ? 16'h9999 : dd_shift[15:0];
        end
      end
      S_PRESENT: begin
        if (state_d == S_HOLDOFF) tmr_d = '0;
      end
      S_HOLDOFF: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (state_d == S_GATE) begin
          cnt_d = '0;
          sat_d = 1'b0;
          tmr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge zybo_clk) begin
    if (rst) begin
      sig_s1_q <= 1'b0;
      sig_s2_q <= 1'b0;
      sig_s3_q <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      tmr_q    <= '0;
      iter_q   <= '0;
      bin_q    <= '0;
      dd_q     <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sig_s1_q <= sig;
      sig_s2_q <= sig_s1_q;
      sig_s3_q <= sig_s2_q;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      tmr_q    <= tmr_d;
      iter_q   <= iter_d;
      bin_q    <= bin_d;
      dd_q     <= dd_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
`timescale 1ns/1ps
// Bench for freq_gate_ctrl: three parameterisations driven by directed stimulus,
// results checked by a queue-based scoreboard on the valid/ready port.
module tb_freq_gate_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Clock / reset
  logic zybo_clk = 1'b0;
  always #5 zybo_clk = ~zybo_clk;

  logic        rst_v[3], sig_v[3], start_v[3], mode_v[3], ready_v[3];
  logic        gate_v[3], busy_v[3], valid_v[3], ovf_v[3];
  logic [15:0] bcd_v[3];
  logic [2:0]  st_v[3];

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt[3] = '{0, 0, 0};
  int period_v[3] = '{0, 0, 0};
  int phase_v[3]  = '{0, 0, 0};

  logic [16:0] exp_q[$];
  logic [16:0] exp_q_b[$];
  logic [16:0] exp_q_c[$];

  freq_gate_ctrl #(.GATE_CYCLES(100), .HOLDOFF_CYCLES(10), .CNT_W(16)) dut_a (
    .zybo_clk(zybo_clk), .rst(rst_v[0]), .sig(sig_v[0]), .start(start_v[0]),
    .mode_cont(mode_v[0]), .result_ready(ready_v[0]), .gate(gate_v[0]),
    .busy(busy_v[0]), .result_valid(valid_v[0]), .bcd_out(bcd_v[0]),
    .overflow(ovf_v[0]), .dbg_state(st_v[0]));

  freq_gate_ctrl #(.GATE_CYCLES(30000), .HOLDOFF_CYCLES(10), .CNT_W(16)) dut_b (
    .zybo_clk(zybo_clk), .rst(rst_v[1]), .sig(sig_v[1]), .start(start_v[1]),
    .mode_cont(mode_v[1]), .result_ready(ready_v[1]), .gate(gate_v[1]),
    .busy(busy_v[1]), .result_valid(valid_v[1]), .bcd_out(bcd_v[1]),
    .overflow(ovf_v[1]), .dbg_state(st_v[1]));

  freq_gate_ctrl #(.GATE_CYCLES(1000), .HOLDOFF_CYCLES(10), .CNT_W(8)) dut_c (
    .zybo_clk(zybo_clk), .rst(rst_v[2]), .sig(sig_v[2]), .start(start_v[2]),
    .mode_cont(mode_v[2]), .result_ready(ready_v[2]), .gate(gate_v[2]),
    .busy(busy_v[2]), .result_valid(valid_v[2]), .bcd_out(bcd_v[2]),
    .overflow(ovf_v[2]), .dbg_state(st_v[2]));

  // Periodic sig per DUT; period 0 holds it low. A gate window that is a multiple
  // of the period always contains window/period rising edges.
  initial begin
    forever begin
      @(negedge zybo_clk);
      for (int i = 0; i < 3; i++) begin
        if (period_v[i] == 0) begin
          sig_v[i]   = 1'b0;
          phase_v[i] = 0;
        end else begin
          sig_v[i]   = (phase_v[i] < period_v[i] / 2);
          phase_v[i] = (phase_v[i] + 1) % period_v[i];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: inputs are driven at negedge, so sampling 2 ns later sees
  // exactly what the next rising edge will act on.
  task automatic mon_one(input int i);
    logic [16:0] exp;
    logic        empty;
    hs_cnt[i]++;
    case (i)
      0:       empty = (exp_q.size() == 0);
      1:       empty = (exp_q_b.size() == 0);
      default: empty = (exp_q_c.size() == 0);
    endcase
    if (empty) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_unexpected dut%0d: got %h with no expected entry", i, {ovf_v[i], bcd_v[i]});
    end else begin
      case (i)
        0:       exp = exp_q.pop_front();
        1:       exp = exp_q_b.pop_front();
        default: exp = exp_q_c.pop_front();
      endcase
      check($sformatf("result_dut%0d", i), {15'd0, ovf_v[i], bcd_v[i]}, {15'd0, exp});
    end
  endtask

  initial begin
    forever begin
      @(negedge zybo_clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (valid_v[i] === 1'b1 && ready_v[i] === 1'b1) mon_one(i);
      end
    end
  end

  // Driver tasks (always called at a negedge)
  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge zybo_clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_hs(input int i, input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while (hs_cnt[i] < target && n < max_cyc) begin
      @(negedge zybo_clk);
      n++;
    end
    if (hs_cnt[i] < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: handshakes %0d required %0d", name, hs_cnt[i], target);
    end
  endtask

  task automatic wait_gate(input int i, input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (gate_v[i] !== lvl && n < max_cyc) begin
      @(negedge zybo_clk);
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, n, base;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; mode_v[i] = 1'b0; ready_v[i] = 1'b1;
    end
    period_v[0] = 10; period_v[1] = 2; period_v[2] = 2;
    repeat (5) @(negedge zybo_clk);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    @(negedge zybo_clk);

    check("rst_gate",  gate_v[0],  0);
    check("rst_busy",  busy_v[0],  0);
    check("rst_valid", valid_v[0], 0);
    check("rst_bcd",   bcd_v[0],   0);
    check("rst_ovf",   ovf_v[0],   0);
    repeat (10) @(negedge zybo_clk);

    // Single shot, period 10 -> 10 edges; latency 1 / 101 / 117
    exp_q.push_back({1'b0, 16'h0010});
    pulse_start(0);
    cyc = 1;
    check("a_gate_rise", gate_v[0], 1);
    while (gate_v[0] && cyc < 400) begin @(negedge zybo_clk); cyc++; end
    check("a_gate_fall_cycle", cyc, 101);
    while (!valid_v[0] && cyc < 400) begin @(negedge zybo_clk); cyc++; end
    check("a_valid_cycle", cyc, 117);
    @(negedge zybo_clk);
    check("a_busy_after_hs", busy_v[0], 0);
    check("a_valid_after_hs", valid_v[0], 0);
    repeat (5) @(negedge zybo_clk);

    // Backpressure: 50 cycles with result_ready low
    ready_v[0] = 1'b0;
    exp_q.push_back({1'b0, 16'h0010});
    base = hs_cnt[0];
    pulse_start(0);
    cyc = 1;
    while (!valid_v[0] && cyc < 400) begin @(negedge zybo_clk); cyc++; end
    check("a_bp_valid_cycle", cyc, 117);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (valid_v[0] !== 1'b1 || bcd_v[0] !== 16'h0010 || gate_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) bad++;
      @(negedge zybo_clk);
    end
    check("a_bp_hold_bad_cycles", bad, 0);
    ready_v[0] = 1'b1;
    wait_hs(0, base + 1, 10, "a_bp_handshake");
    check("a_bp_busy_after_hs", busy_v[0], 0);
    repeat (5) @(negedge zybo_clk);

    // Mid-gate reset, then a fresh measurement
    pulse_start(0);
    repeat (49) @(negedge zybo_clk);
    check("a_gate_at_cycle50", gate_v[0], 1);
    rst_v[0] = 1'b1;
    @(negedge zybo_clk);
    rst_v[0] = 1'b0;
    check("a_mrst_gate",  gate_v[0],  0);
    check("a_mrst_busy",  busy_v[0],  0);
    check("a_mrst_bcd",   bcd_v[0],   0);
    check("a_mrst_valid", valid_v[0], 0);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      if (valid_v[0] !== 1'b0) bad++;
      @(negedge zybo_clk);
    end
    check("a_mrst_no_valid_cycles", bad, 0);
    exp_q.push_back({1'b0, 16'h0010});
    base = hs_cnt[0];
    pulse_start(0);
    wait_hs(0, base + 1, 200, "a_fresh_result");
    repeat (5) @(negedge zybo_clk);

    // Continuous mode from reset, period 4 -> 25 edges per gate
    rst_v[0] = 1'b1; mode_v[0] = 1'b1; period_v[0] = 0;
    repeat (3) @(negedge zybo_clk);
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 16'h0025});
    base = hs_cnt[0];
    period_v[0] = 4; rst_v[0] = 1'b0;
    wait_gate(0, 1'b1, 20, n);
    check("a_cont_first_gate_delay", n, 1);
    wait_gate(0, 1'b0, 200, n);
    wait_gate(0, 1'b1, 200, n);
    check("a_cont_gap1", n, 27);
    wait_gate(0, 1'b0, 200, n);
    wait_gate(0, 1'b1, 200, n);
    check("a_cont_gap2", n, 27);
    wait_hs(0, base + 3, 300, "a_cont_results");
    n = 0;
    while (st_v[0] !== ST_HOLDOFF && n < 50) begin @(negedge zybo_clk); n++; end
    check("a_cont_in_holdoff", st_v[0], ST_HOLDOFF);
    mode_v[0] = 1'b0;
    @(negedge zybo_clk);
    check("a_stop_busy", busy_v[0], 0);
    check("a_stop_state", st_v[0], ST_IDLE);
    repeat (20) @(negedge zybo_clk);
    check("a_stop_still_idle", busy_v[0], 0);

    // Count above 9999: 15000 edges in 30000 cycles
    exp_q_b.push_back({1'b1, 16'h9999});
    pulse_start(1);
    wait_hs(1, 1, 31000, "b_overflow_result");

    // Saturation of an 8-bit counter: 500 edges clamp at 255
    exp_q_c.push_back({1'b1, 16'h9999});
    pulse_start(2);
    cyc = 1;
    while (!valid_v[2] && cyc < 2000) begin @(negedge zybo_clk); cyc++; end
    check("c_valid_cycle", cyc, 1009);
    wait_hs(2, 1, 10, "c_sat_result");

    repeat (5) @(negedge zybo_clk);
    check("a_queue_left", exp_q.size(), 0);
    check("b_queue_left", exp_q_b.size(), 0);
    check("c_queue_left", exp_q_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
